// File: rtl/arm_id_stage_p.sv
// ARM instruction decode stage: register file with write-through reads,
// opcode decode, condition-code check, RAW hazard detection and the
// ID/EX pipeline register.
// Optional feature macro ARM_ID_FORWARD_EN: when defined, only load-use
// hazards stall and src1_out/src2_out carry source addresses to the
// forwarding unit; when undefined, every RAW dependency on EXE/MEM stalls
// and src1_out/src2_out are held 0.
module arm_id_stage_p #(
    parameter  int DATA_W   = 32,
    parameter  int PC_W     = 32,
    parameter  int NUM_REGS = 16,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              instr_valid,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [31:0]       instruction,
    input  logic [3:0]        status_in,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              mem_wb_en,
    input  logic [REG_AW-1:0] mem_dest,
    output logic              hazard,
    output logic              id_valid,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] rn_val,
    output logic [DATA_W-1:0] rm_val,
    output logic [REG_AW-1:0] dest,
    output logic              imm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm,
    output logic [8:0]        ctrl_out,
    output logic [REG_AW-1:0] src1_out,
    output logic [REG_AW-1:0] src2_out
);

    // Instruction fields
    logic [3:0]        cond;
    logic [1:0]        mode;
    logic              imm_bit;
    logic [3:0]        opcode;
    logic              s_bit;
    logic [REG_AW-1:0] rn_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [REG_AW-1:0] rm_addr;
    logic [REG_AW-1:0] src2_addr;
    logic              is_str;

    assign cond      = instruction[31:28];
    assign mode      = instruction[27:26];
    assign imm_bit   = instruction[25];
    assign opcode    = instruction[24:21];
    assign s_bit     = instruction[20];
    assign rn_addr   = instruction[16 +: REG_AW];
    assign rd_addr   = instruction[12 +: REG_AW];
    assign rm_addr   = instruction[0 +: REG_AW];
    assign is_str    = (mode == 2'b01) && !s_bit;
    // STR reads the stored register through the second read port.
    assign src2_addr = is_str ? rd_addr : rm_addr;

    // Register file
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rn_data;
    logic [DATA_W-1:0] src2_data;

    // Register file write port; contents cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file must read as zero after reset, so it is
            // built from resettable flops rather than an inferred RAM.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            // NOTE: non-blocking assignments for all clocked state so every
            // flop samples pre-edge values regardless of block ordering.
            regs[wb_dest] <= wb_value;
        end
    end

    // Write-through lets a same-cycle writeback reach the reader.
    assign rn_data   = (wb_en && wb_dest == rn_addr)   ? wb_value : regs[rn_addr];
    assign src2_data = (wb_en && wb_dest == src2_addr) ? wb_value : regs[src2_addr];

    // Control decode
    logic       dec_wb_en;
    logic       dec_mem_r_en;
    logic       dec_mem_w_en;
    logic [3:0] dec_exe_cmd;
    logic       dec_branch;
    logic       dec_s;

    // Translate mode/opcode into execute-stage control bits.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned, which would infer a latch.
        dec_wb_en    = 1'b0;
        dec_mem_r_en = 1'b0;
        dec_mem_w_en = 1'b0;
        dec_exe_cmd  = 4'b0000;
        dec_branch   = 1'b0;
        dec_s        = 1'b0;
        case (mode)
            2'b00: begin
                dec_s = s_bit;
                case (opcode)
                    4'b1101: begin dec_exe_cmd = 4'b0001; dec_wb_en = 1'b1; end // MOV
                    4'b1111: begin dec_exe_cmd = 4'b1001; dec_wb_en = 1'b1; end // MVN
                    4'b0100: begin dec_exe_cmd = 4'b0010; dec_wb_en = 1'b1; end // ADD
                    4'b0101: begin dec_exe_cmd = 4'b0011; dec_wb_en = 1'b1; end // ADC
                    4'b0010: begin dec_exe_cmd = 4'b0100; dec_wb_en = 1'b1; end // SUB
                    4'b0110: begin dec_exe_cmd = 4'b0101; dec_wb_en = 1'b1; end // SBC
                    4'b0000: begin dec_exe_cmd = 4'b0110; dec_wb_en = 1'b1; end // AND
                    4'b1100: begin dec_exe_cmd = 4'b0111; dec_wb_en = 1'b1; end // ORR
                    4'b0001: begin dec_exe_cmd = 4'b1000; dec_wb_en = 1'b1; end // EOR
                    4'b1010: begin dec_exe_cmd = 4'b0100; dec_s = 1'b1; end     // CMP
                    4'b1000: begin dec_exe_cmd = 4'b0110; dec_s = 1'b1; end     // TST
                    default: dec_s = 1'b0;
                endcase
            end
            2'b01: begin
                dec_exe_cmd = 4'b0010;
                if (s_bit) begin
                    dec_wb_en    = 1'b1;
                    dec_mem_r_en = 1'b1;
                end else begin
                    dec_mem_w_en = 1'b1;
                end
            end
            2'b10: dec_branch = 1'b1;
            default: ;
        endcase
    end

    // Condition check against {N,Z,C,V}
    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;

    assign {flag_n, flag_z, flag_c, flag_v} = status_in;

    // Evaluate the ARM condition field.
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    logic [8:0] dec_ctrl;
    assign dec_ctrl = cond_pass ? {dec_wb_en, dec_mem_r_en, dec_mem_w_en,
                                   dec_exe_cmd, dec_branch, dec_s} : 9'd0;

    // Source usage and hazard detection
    logic use_rn;
    logic use_src2;
    logic raw;

    assign use_rn   = !((mode == 2'b10) ||
                        ((mode == 2'b00) && (opcode == 4'b1101 || opcode == 4'b1111)));
    assign use_src2 = ((mode == 2'b00) && !imm_bit) || is_str;

`ifdef ARM_ID_FORWARD_EN
    // Forwarding covers ALU results; only a load in EXE forces a stall.
    assign raw = exe_wb_en && exe_mem_r_en &&
                 ((use_rn && rn_addr == exe_dest) || (use_src2 && src2_addr == exe_dest));

    logic unused_mem_info;
    assign unused_mem_info = mem_wb_en ^ (^mem_dest);
`else
    // Without forwarding, any pending write to a used source stalls.
    assign raw = (use_rn && ((exe_wb_en && rn_addr == exe_dest) ||
                             (mem_wb_en && rn_addr == mem_dest))) ||
                 (use_src2 && ((exe_wb_en && src2_addr == exe_dest) ||
                               (mem_wb_en && src2_addr == mem_dest)));

    logic unused_mem_r_en;
    assign unused_mem_r_en = exe_mem_r_en;
`endif

    assign hazard = instr_valid && !flush && raw;

    // ID/EX pipeline register; flush or stall loads a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid      <= 1'b0;
            pc_out        <= '0;
            rn_val        <= '0;
            rm_val        <= '0;
            dest          <= '0;
            imm           <= 1'b0;
            shift_operand <= '0;
            signed_imm    <= '0;
            ctrl_out      <= '0;
            src1_out      <= '0;
            src2_out      <= '0;
        end else begin
            pc_out        <= pc_in;
            rn_val        <= rn_data;
            rm_val        <= src2_data;
            dest          <= rd_addr;
            imm           <= imm_bit;
            shift_operand <= instruction[11:0];
            signed_imm    <= instruction[23:0];
`ifdef ARM_ID_FORWARD_EN
            src1_out      <= rn_addr;
            src2_out      <= src2_addr;
`else
            src1_out      <= '0;
            src2_out      <= '0;
`endif
            if (flush || hazard) begin
                id_valid <= 1'b0;
                ctrl_out <= '0;
            end else begin
                id_valid <= instr_valid;
                ctrl_out <= dec_ctrl;
            end
        end
    end

endmodule

// File: tb/tb_arm_id_stage_p.sv
// Self-checking bench for arm_id_stage_p: a table-driven model predicts the
// ID/EX contents and the hazard output, compared every falling edge, plus
// hand-computed literal checks on key scenarios.
module tb_arm_id_stage_p;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] pc_in = 32'h0000_1000;
    logic [31:0] instruction = 32'h0;
    logic [3:0]  status_in = 4'h0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_dest = 4'h0;
    logic [31:0] wb_value = 32'h0;
    logic        exe_wb_en = 1'b0;
    logic        exe_mem_r_en = 1'b0;
    logic [3:0]  exe_dest = 4'h0;
    logic        mem_wb_en = 1'b0;
    logic [3:0]  mem_dest = 4'h0;

    logic        hazard;
    logic        id_valid;
    logic [31:0] pc_out;
    logic [31:0] rn_val;
    logic [31:0] rm_val;
    logic [3:0]  dest;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm;
    logic [8:0]  ctrl_out;
    logic [3:0]  src1_out;
    logic [3:0]  src2_out;

    arm_id_stage_p dut (
        .clk(clk), .rst(rst), .flush(flush), .instr_valid(instr_valid),
        .pc_in(pc_in), .instruction(instruction), .status_in(status_in),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .hazard(hazard), .id_valid(id_valid), .pc_out(pc_out),
        .rn_val(rn_val), .rm_val(rm_val), .dest(dest), .imm(imm),
        .shift_operand(shift_operand), .signed_imm(signed_imm),
        .ctrl_out(ctrl_out), .src1_out(src1_out), .src2_out(src2_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Data-processing table indexed by opcode: legal?, writes?, flags forced?, exe_cmd
    bit       op_legal [16];
    bit       op_wr    [16];
    bit       op_force [16];
    bit [3:0] op_cmd   [16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            op_legal[i] = 0; op_wr[i] = 0; op_force[i] = 0; op_cmd[i] = 0;
        end
        op_legal[13] = 1; op_wr[13] = 1; op_cmd[13] = 1;  // MOV
        op_legal[15] = 1; op_wr[15] = 1; op_cmd[15] = 9;  // MVN
        op_legal[4]  = 1; op_wr[4]  = 1; op_cmd[4]  = 2;  // ADD
        op_legal[5]  = 1; op_wr[5]  = 1; op_cmd[5]  = 3;  // ADC
        op_legal[2]  = 1; op_wr[2]  = 1; op_cmd[2]  = 4;  // SUB
        op_legal[6]  = 1; op_wr[6]  = 1; op_cmd[6]  = 5;  // SBC
        op_legal[0]  = 1; op_wr[0]  = 1; op_cmd[0]  = 6;  // AND
        op_legal[12] = 1; op_wr[12] = 1; op_cmd[12] = 7;  // ORR
        op_legal[1]  = 1; op_wr[1]  = 1; op_cmd[1]  = 8;  // EOR
        op_legal[10] = 1; op_force[10] = 1; op_cmd[10] = 4; // CMP
        op_legal[8]  = 1; op_force[8]  = 1; op_cmd[8]  = 6; // TST
    end

    logic [31:0] mregs [16];

    function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0: return z;           1: return !z;
            2: return cy;          3: return !cy;
            4: return n;           5: return !n;
            6: return v;           7: return !v;
            8: return cy && !z;    9: return !cy || z;
            10: return n == v;     11: return n != v;
            12: return !z && n == v;
            13: return z || n != v;
            14: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [8:0] m_ctrl(input logic [31:0] ins, input logic [3:0] f);
        int op;
        op = int'(ins[24:21]);
        if (!m_cond(ins[31:28], f)) return 9'd0;
        if (ins[27:26] == 2'b00) begin
            if (!op_legal[op]) return 9'd0;
            return {op_wr[op], 2'b00, op_cmd[op], 1'b0, op_force[op] | ins[20]};
        end
        if (ins[27:26] == 2'b01)
            return ins[20] ? 9'b1_1_0_0010_0_0 : 9'b0_0_1_0010_0_0;
        if (ins[27:26] == 2'b10) return 9'b0_0_0_0000_1_0;
        return 9'd0;
    endfunction

    function automatic bit m_is_str(input logic [31:0] ins);
        return ins[27:26] == 2'b01 && !ins[20];
    endfunction

    function automatic logic [3:0] m_src2(input logic [31:0] ins);
        return m_is_str(ins) ? ins[15:12] : ins[3:0];
    endfunction

    function automatic bit m_use_rn(input logic [31:0] ins);
        if (ins[27:26] == 2'b10) return 0;
        if (ins[27:26] == 2'b00 && (ins[24:21] == 4'd13 || ins[24:21] == 4'd15)) return 0;
        return 1;
    endfunction

    function automatic bit m_use_src2(input logic [31:0] ins);
        return (ins[27:26] == 2'b00 && !ins[25]) || m_is_str(ins);
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        return (wb_en && wb_dest == a) ? wb_value : mregs[a];
    endfunction

    // Does a pending writer with this destination block the current instruction?
    function automatic bit m_dep(input logic [3:0] d);
        return (m_use_rn(instruction) && instruction[19:16] == d) ||
               (m_use_src2(instruction) && m_src2(instruction) == d);
    endfunction

    function automatic bit m_hazard();
        bit stall;
`ifdef ARM_ID_FORWARD_EN
        stall = exe_wb_en && exe_mem_r_en && m_dep(exe_dest);
`else
        stall = (exe_wb_en && m_dep(exe_dest)) || (mem_wb_en && m_dep(mem_dest));
`endif
        return instr_valid && !flush && stall;
    endfunction

    logic        exp_valid = 0;
    logic [8:0]  exp_ctrl = 0;
    logic [31:0] exp_pc = 0, exp_rn = 0, exp_rm = 0;
    logic [3:0]  exp_dest = 0, exp_s1 = 0, exp_s2 = 0;
    logic        exp_imm = 0;
    logic [31:0] exp_ins = 0;

    // Model state advances with the DUT clock and reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mregs[i] <= 32'h0;
            exp_valid <= 0; exp_ctrl <= 0; exp_pc <= 0; exp_rn <= 0; exp_rm <= 0;
            exp_dest <= 0; exp_imm <= 0; exp_ins <= 0; exp_s1 <= 0; exp_s2 <= 0;
        end else begin
            if (wb_en) mregs[wb_dest] <= wb_value;
            exp_pc   <= pc_in;
            exp_rn   <= m_read(instruction[19:16]);
            exp_rm   <= m_read(m_src2(instruction));
            exp_dest <= instruction[15:12];
            exp_imm  <= instruction[25];
            exp_ins  <= instruction;
`ifdef ARM_ID_FORWARD_EN
            exp_s1   <= instruction[19:16];
            exp_s2   <= m_src2(instruction);
`else
            exp_s1   <= 4'h0;
            exp_s2   <= 4'h0;
`endif
            if (flush || m_hazard()) begin
                exp_valid <= 0;
                exp_ctrl  <= 0;
            end else begin
                exp_valid <= instr_valid;
                exp_ctrl  <= m_ctrl(instruction, status_in);
            end
        end
    end

    // Compare process: outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("hazard", 64'(hazard), 64'(m_hazard()));
            check("id_valid", 64'(id_valid), 64'(exp_valid));
            check("ctrl_out", 64'(ctrl_out), 64'(exp_ctrl));
`ifndef ARM_ID_FORWARD_EN
            check("src1_out_held", 64'(src1_out), 64'(exp_s1));
            check("src2_out_held", 64'(src2_out), 64'(exp_s2));
`endif
            if (exp_valid) begin
                check("pc_out", 64'(pc_out), 64'(exp_pc));
                check("rn_val", 64'(rn_val), 64'(exp_rn));
                check("rm_val", 64'(rm_val), 64'(exp_rm));
                check("dest", 64'(dest), 64'(exp_dest));
                check("imm", 64'(imm), 64'(exp_imm));
                check("shift_operand", 64'(shift_operand), 64'(exp_ins[11:0]));
                check("signed_imm", 64'(signed_imm), 64'(exp_ins[23:0]));
`ifdef ARM_ID_FORWARD_EN
                check("src1_out", 64'(src1_out), 64'(exp_s1));
                check("src2_out", 64'(src2_out), 64'(exp_s2));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        pc_in = pc_in + 32'd4;
    endtask

    localparam logic [31:0] ADD_R1_R2_R3 = 32'hE082_1003;
    localparam logic [31:0] SUB_R4_R2_1  = 32'hE242_4001;

    initial begin
        logic [31:0] ins;
        logic hz_exp;

        tick();
        tick();
        check("rst_id_valid", 64'(id_valid), 64'h0);
        check("rst_ctrl", 64'(ctrl_out), 64'h0);
        check("rst_pc", 64'(pc_out), 64'h0);
        check("rst_rn_rm", 64'({rn_val, rm_val}), 64'h0);
        rst = 1'b0;
        chk_on = 1'b1;
        tick();

        // ADD R1,R2,R3 with R2 written in the same cycle
        instruction = ADD_R1_R2_R3; instr_valid = 1; status_in = 4'h0;
        wb_en = 1; wb_dest = 4'd2; wb_value = 32'h55;
        tick();
        check("add_ctrl", 64'(ctrl_out), 64'h108);
        check("add_dest", 64'(dest), 64'd1);
        check("add_valid", 64'(id_valid), 64'd1);
        check("wt_rn_val", 64'(rn_val), 64'h55);

        // Store R3 without a valid instruction, then read stored values
        instr_valid = 0; wb_dest = 4'd3; wb_value = 32'h1234;
        tick();
        check("idle_valid", 64'(id_valid), 64'd0);
        wb_en = 0; instr_valid = 1;
        tick();
        check("stored_rn", 64'(rn_val), 64'h55);
        check("stored_rm", 64'(rm_val), 64'h1234);

        // ADDEQ with Z clear then Z set
        instruction = 32'h0082_1003; status_in = 4'b0000;
        tick();
        check("addeq_fail_ctrl", 64'(ctrl_out), 64'h0);
        check("addeq_fail_valid", 64'(id_valid), 64'd1);
        status_in = 4'b0100;
        tick();
        check("addeq_pass_wb", 64'(ctrl_out[8]), 64'd1);

        // Condition sweep under several flag patterns
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 4; k++) begin
                ins = ADD_R1_R2_R3;
                ins[31:28] = 4'(c);
                instruction = ins;
                status_in = 4'(k * 5);
                tick();
            end
        end
        status_in = 4'b0000;

        // RAW on an ALU result in EXE
        instruction = SUB_R4_R2_1; exe_wb_en = 1; exe_dest = 4'd2;
        #1;
`ifdef ARM_ID_FORWARD_EN
        hz_exp = 1'b0;
`else
        hz_exp = 1'b1;
`endif
        check("alu_raw_hazard", 64'(hazard), 64'(hz_exp));
        tick();
        check("alu_raw_valid", 64'(id_valid), 64'(!hz_exp));
`ifdef ARM_ID_FORWARD_EN
        check("alu_raw_src1", 64'(src1_out), 64'd2);
`endif

        // Load-use: stalls in every build, then issues once EXE clears
        instruction = ADD_R1_R2_R3; exe_mem_r_en = 1; exe_dest = 4'd3;
        #1;
        check("load_use_hazard", 64'(hazard), 64'd1);
        tick();
        check("load_use_bubble", 64'(id_valid), 64'd0);
        check("load_use_bubble_ctrl", 64'(ctrl_out), 64'd0);
        exe_wb_en = 0; exe_mem_r_en = 0;
        tick();
        check("load_use_issue", 64'(id_valid), 64'd1);
        check("load_use_ctrl", 64'(ctrl_out), 64'h108);

        // RAW against MEM stage
        mem_wb_en = 1; mem_dest = 4'd3;
        tick();
        mem_dest = 4'd9;
        tick();
        mem_wb_en = 0;

        // Flush overrides a pending hazard
        exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 4'd2; flush = 1;
        #1;
        check("flush_hazard", 64'(hazard), 64'd0);
        tick();
        check("flush_bubble", 64'(id_valid), 64'd0);
        flush = 0;

        // Decode coverage; MOV ignores Rn so no stall on R2
        instruction = 32'hE3A0_2007;             // MOV R2,#7
        tick();
        check("mov_no_stall", 64'(id_valid), 64'd1);
        exe_wb_en = 0; exe_mem_r_en = 0;
        instruction = 32'hE352_0005;             // CMP R2,#5
        tick();
        check("cmp_ctrl", 64'(ctrl_out), 64'h011);
        instruction = 32'hE582_5004;             // STR R5,[R2,#4]
        wb_en = 1; wb_dest = 4'd5; wb_value = 32'hCAFE_0005;
        tick();
        wb_en = 0;
        check("str_ctrl", 64'(ctrl_out), 64'h048);
        check("str_rm_val", 64'(rm_val), 64'hCAFE_0005);
        instruction = 32'hE592_6000;             // LDR R6,[R2]
        tick();
        check("ldr_ctrl", 64'(ctrl_out), 64'h188);
        instruction = 32'hEA00_0010;             // B
        tick();
        check("b_ctrl", 64'(ctrl_out), 64'h002);
        instruction = 32'hE1F0_3004; tick();     // MVN R3,R4
        instruction = 32'hE111_0002; tick();     // TST R1,R2
        instruction = 32'hE0B1_2003; tick();     // ADCS
        instruction = 32'hE063_1002; tick();     // RSB (unlisted)
        instruction = 32'hEC00_0000; tick();     // mode 11
        instruction = 32'hE1A0_1000; tick();     // MOV R1,R0 (src2 used)
        instruction = 32'hE7D2_0003; tick();     // LDRB-like word, S=1

        // Asynchronous reset mid-cycle during a stall
        instruction = ADD_R1_R2_R3; status_in = 4'h0;
        tick();
        exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 4'd3;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(id_valid), 64'd0);
        check("async_rst_ctrl", 64'(ctrl_out), 64'd0);
        check("async_rst_pc", 64'(pc_out), 64'd0);
        check("rst_stall_hazard", 64'(hazard), 64'd1);
        instr_valid = 0;
        #1;
        check("rst_hazard_drop", 64'(hazard), 64'd0);
        tick();
        rst = 1'b0; exe_wb_en = 0; exe_mem_r_en = 0; instr_valid = 1;
        tick();
        check("post_rst_rn", 64'(rn_val), 64'd0);
        check("post_rst_valid", 64'(id_valid), 64'd1);
        instr_valid = 0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
